sent_rx_crc_check: RTL
======================

// Module: sent_rx_crc_check
// PURPOSE
//  Receive-side SENT CRC4 checker (SAE J2716). Sits after the SENT RX pulse decoder.
//  - Takes one status nibble, DATA_NIBBLES data nibbles and one CRC nibble per frame.
//  - Recomputes CRC4 over the data nibbles, compares it with the received CRC nibble,
//    then presents the frame with an ok/err verdict and a saturating error counter.
// PARAMETERS
//  DATA_NIBBLES  6   data nibbles per frame; legal range 1..6
//  ERR_CNT_W     16  width of the saturating CRC error counter
// PORTS
//  clk          in   1                clock
//  reset        in   1                async, active-high reset
//  frame_start  in   1                1-cycle pulse: sync/cal pulse detected, new frame follows
//  frame_abort  in   1                1-cycle pulse: decoder pulse error, drop current frame
//  nib_valid    in   1                nib_data valid this cycle, 1 nibble per pulse
//  nib_data     in   4                decoded nibble (status, data..., crc, in order)
//  busy         out  1                frame in progress (not IDLE)
//  frame_valid  out  1                1-cycle pulse: frame complete, outputs below valid
//  crc_ok       out  1                with frame_valid: received CRC == computed CRC
//  crc_err      out  1                with frame_valid: received CRC != computed CRC
//  status_nib   out  4                received status nibble, held until next frame_valid
//  data_out     out  4*DATA_NIBBLES   data nibbles; first received in MS nibble; held
//  crc_rx       out  4                received CRC nibble, held
//  crc_calc     out  4                computed CRC, held
//  err_cnt      out  ERR_CNT_W        count of crc_err pulses, saturates at all-ones
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, CRC register = seed 4'h5.
//  CRC step, table method: crc <= T[crc] ^ nib.
//   T = {0,D,7,A,E,3,9,4,1,C,6,B,F,2,8,5} (hex, index 0..15).
//   Equals poly x^4+x^3+x^2+1, seed 4'b0101.
//  Status nibble is NOT included in the CRC.
//  FSM:
//   IDLE:   frame_start -> STATUS, crc<=5, nibble count<=0. nib_valid ignored.
//   STATUS: nib_valid -> latch status_nib -> DATA.
//   DATA:   each nib_valid: CRC step, shift into data shadow, count++.
//           After DATA_NIBBLES nibbles -> CRC.
//   CRC:    nib_valid -> latch crc_rx -> AUG.
//   AUG:    crc <= T[crc] (zero-nibble augmentation) -> DONE. No input consumed.
//   DONE:   1 cycle. Copy shadow to outputs.
//           Pulse frame_valid with exactly one of crc_ok/crc_err.
//           Increment err_cnt on error -> IDLE.
//  Latency: frame_valid asserts 2 cycles after the cycle the CRC nibble is accepted.
//  busy = 1 in STATUS..DONE.
//  Outputs are updated only in DONE. Aborted or restarted frames leave prior values intact.
//  frame_start in any non-IDLE state: discard partial frame, restart at STATUS.
//   No frame_valid for the discarded frame.
//  frame_abort in any state -> IDLE, no frame_valid.
//   Simultaneous with frame_start: abort wins.
//  frame_start and nib_valid in the same cycle: nibble discarded.
//  nib_valid in AUG/DONE: ignored; the next frame requires frame_start.
//  err_cnt at all-ones: holds, no wrap.
//  Reset mid-frame: immediate return to reset state; no partial output.
// CONFIGURATION
//  SENT_LEGACY_CRC_EN defined: AUG state removed (pre-2010 CRC, no augmentation).
//   DONE follows CRC directly; latency is 1 cycle after the CRC nibble.
//  Not defined (default): recommended CRC with augmentation, as above.
// TESTING
//  1. status=0, data 0,0,0,0,0,0, crc=5
//     -> frame_valid 2 cycles after CRC nibble, crc_ok=1, crc_calc=5.
//  2. status=3, data 1,2,3,4,5,6, crc=2
//     -> crc_ok=1, data_out=24'h123456, status_nib=3.
//     Repeat with crc=7 -> crc_err=1, err_cnt=1.
//  3. frame_start after 3 data nibbles, then full good frame (test 1)
//     -> exactly one frame_valid, crc_ok=1.
//  4. frame_abort during DATA
//     -> busy=0 next cycle, no frame_valid, outputs keep prior frame.
//  5. Force err_cnt to all-ones via repeated bad frames (ERR_CNT_W=2: 4 bad frames)
//     -> err_cnt stays 2'b11.
//  6. SENT_LEGACY_CRC_EN: data all 0 with crc=F -> crc_ok=1, latency 1 cycle;
//     data 1..6 with crc=D -> crc_ok=1.

Source files
------------

// File: rtl/sent_rx_crc_check.sv
// Receive-side SENT CRC4 checker: collects status/data/CRC nibbles, recomputes the CRC and reports ok/err.
// Define SENT_LEGACY_CRC_EN for the pre-2010 CRC without zero-nibble augmentation (one cycle less latency).
module sent_rx_crc_check #(
    parameter int DATA_NIBBLES = 6,
    parameter int ERR_CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic                      frame_abort,
    input  logic                      nib_valid,
    input  logic [3:0]                nib_data,
    output logic                      busy,
    output logic                      frame_valid,
    output logic                      crc_ok,
    output logic                      crc_err,
    output logic [3:0]                status_nib,
    output logic [4*DATA_NIBBLES-1:0] data_out,
    output logic [3:0]                crc_rx,
    output logic [3:0]                crc_calc,
    output logic [ERR_CNT_W-1:0]      err_cnt
);
    localparam int         DW       = 4 * DATA_NIBBLES;
    localparam logic [3:0] CRC_SEED = 4'h5;
    localparam logic [2:0] LAST_IDX = 3'(DATA_NIBBLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_STATUS, S_DATA, S_CRC, S_AUG, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [3:0]           crc_q, crc_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [3:0]           status_sh_q, status_sh_d;
    logic [DW-1:0]        data_sh_q, data_sh_d;
    logic [3:0]           crc_rx_sh_q, crc_rx_sh_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 crc_ok_q, crc_ok_d;
    logic                 crc_err_q, crc_err_d;
    logic [3:0]           status_nib_q, status_nib_d;
    logic [DW-1:0]        data_out_q, data_out_d;
    logic [3:0]           crc_rx_q, crc_rx_d;
    logic [3:0]           crc_calc_q, crc_calc_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 load;
    logic [3:0]           crc_final;
    logic                 match;

    // One table step of poly x^4+x^3+x^2+1.
    function automatic logic [3:0] crc_tab(input logic [3:0] idx);
        case (idx)
            4'h0: crc_tab = 4'h0;  4'h1: crc_tab = 4'hD;  4'h2: crc_tab = 4'h7;  4'h3: crc_tab = 4'hA;
            4'h4: crc_tab = 4'hE;  4'h5: crc_tab = 4'h3;  4'h6: crc_tab = 4'h9;  4'h7: crc_tab = 4'h4;
            4'h8: crc_tab = 4'h1;  4'h9: crc_tab = 4'hC;  4'hA: crc_tab = 4'h6;  4'hB: crc_tab = 4'hB;
            4'hC: crc_tab = 4'hF;  4'hD: crc_tab = 4'h2;  4'hE: crc_tab = 4'h8;  default: crc_tab = 4'h5;
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        cnt_d         = cnt_q;
        status_sh_d   = status_sh_q;
        data_sh_d     = data_sh_q;
        crc_rx_sh_d   = crc_rx_sh_q;
        frame_valid_d = 1'b0;
        crc_ok_d      = 1'b0;
        crc_err_d     = 1'b0;
        status_nib_d  = status_nib_q;
        data_out_d    = data_out_q;
        crc_rx_d      = crc_rx_q;
        crc_calc_d    = crc_calc_q;
        err_cnt_d     = err_cnt_q;
        load          = 1'b0;
        crc_final     = crc_q;
        match         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_STATUS;
                    crc_d   = CRC_SEED;
                    cnt_d   = '0;
                end
            end
            S_STATUS: begin
                if (nib_valid) begin
                    status_sh_d = nib_data;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                if (nib_valid) begin
                    crc_d     = crc_tab(crc_q) ^ nib_data;
                    data_sh_d = (data_sh_q << 4) | DW'(nib_data);
                    cnt_d     = cnt_q + 3'd1;
                    if (cnt_q == LAST_IDX) state_d = S_CRC;
                end
            end
            S_CRC: begin
                if (nib_valid) begin
                    crc_rx_sh_d = nib_data;
`ifdef SENT_LEGACY_CRC_EN
                    load    = 1'b1;
                    state_d = S_DONE;
`else
                    state_d = S_AUG;
`endif
                end
            end
`ifndef SENT_LEGACY_CRC_EN
            S_AUG: begin
                crc_d     = crc_tab(crc_q);
                crc_final = crc_d;
                load      = 1'b1;
                state_d   = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A restart or abort cancels any result that would have been published on this edge.
        if (frame_start && state_q != S_IDLE) begin
            state_d = S_STATUS;
            crc_d   = CRC_SEED;
            cnt_d   = '0;
            load    = 1'b0;
        end
        if (frame_abort) begin
            state_d = S_IDLE;
            load    = 1'b0;
        end

        // Outputs are registered on the edge into DONE so they are valid while DONE is active.
        if (load) begin
            match         = (crc_rx_sh_d == crc_final);
            frame_valid_d = 1'b1;
            crc_ok_d      = match;
            crc_err_d     = !match;
            status_nib_d  = status_sh_q;
            data_out_d    = data_sh_q;
            crc_rx_d      = crc_rx_sh_d;
            crc_calc_d    = crc_final;
            if (!match && err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            crc_q         <= CRC_SEED;
            cnt_q         <= '0;
            status_sh_q   <= '0;
            data_sh_q     <= '0;
            crc_rx_sh_q   <= '0;
            frame_valid_q <= 1'b0;
            crc_ok_q      <= 1'b0;
            crc_err_q     <= 1'b0;
            status_nib_q  <= '0;
            data_out_q    <= '0;
            crc_rx_q      <= '0;
            crc_calc_q    <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            cnt_q         <= cnt_d;
            status_sh_q   <= status_sh_d;
            data_sh_q     <= data_sh_d;
            crc_rx_sh_q   <= crc_rx_sh_d;
            frame_valid_q <= frame_valid_d;
            crc_ok_q      <= crc_ok_d;
            crc_err_q     <= crc_err_d;
            status_nib_q  <= status_nib_d;
            data_out_q    <= data_out_d;
            crc_rx_q      <= crc_rx_d;
            crc_calc_q    <= crc_calc_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign frame_valid = frame_valid_q;
    assign crc_ok      = crc_ok_q;
    assign crc_err     = crc_err_q;
    assign status_nib  = status_nib_q;
    assign data_out    = data_out_q;
    assign crc_rx      = crc_rx_q;
    assign crc_calc    = crc_calc_q;
    assign err_cnt     = err_cnt_q;
endmodule
